// File: rtl/chain_arb_pkg.sv
// Shared types and limits for the chain round-robin arbiter.
// Optional requester lock is enabled with CHAIN_ARB_LOCK_EN.
package chain_arb_pkg;

    localparam int REQ_MIN   = 2;
    localparam int REQ_MAX   = 16;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 8;
    localparam int MAX_IDW   = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_FLOW,
        ARB_STALL
    } arb_state_t;

    typedef struct packed {
        logic               valid;
        logic               data;
        logic [MAX_IDW-1:0] id;
    } stage_t;

    localparam int STAGE_W = $bits(stage_t);

endpackage

// File: rtl/chain_rr_arbiter_stage.sv
// One register of the shared chain: holds a packed stage entry,
// loads when enabled, clears on synchronous active-low reset.
module chain_stage
    import chain_arb_pkg::*;
#(
    parameter int W = STAGE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/chain_rr_arbiter.sv
// Round-robin arbiter feeding a DEPTH-stage single-bit tagged chain.
// Define CHAIN_ARB_LOCK_EN to add the i_lock priority-hold input.
module chain_rr_arbiter
    import chain_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DEPTH   = 3,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_data,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_valid,
    output logic               o_data,
    output logic [IDW-1:0]     o_id,
    output logic [DEPTH-1:0]   o_taps,
    input  logic               i_ready,
`ifdef CHAIN_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0] i_lock,
`endif
    output logic               o_busy
);

    stage_t             stg_q [DEPTH];
    logic [STAGE_W-1:0] stg_raw [DEPTH];
    stage_t             in_e;
    logic [DEPTH-1:0]   vld;
    logic [DEPTH-1:0]   vld_nxt;
    logic               adv;
    logic               xfer;
    logic               lock_hit;
    logic               found;
    int                 idx;
    logic [NUM_REQ-1:0] rr_gnt;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW-1:0]     start;
    logic [IDW-1:0]     ptr_q, ptr_d;
    arb_state_t         state_q, state_d;
    logic               unused_id;

    assign adv = !(stg_q[DEPTH-1].valid && !i_ready);

`ifdef CHAIN_ARB_LOCK_EN
    logic lock_q, lock_d;

    assign lock_hit = |(o_gnt & i_lock);

    // A lock owner that let go of req or lock yields to its successor.
    always_comb begin
        start = ptr_q;
        if (lock_q && !(i_req[ptr_q] && i_lock[ptr_q])) begin
            start = (ptr_q == IDW'(NUM_REQ - 1)) ? '0 : ptr_q + IDW'(1);
        end
    end

    assign lock_d = xfer ? lock_hit : lock_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    assign lock_hit = 1'b0;
    assign start    = ptr_q;
`endif

    always_comb begin
        rr_gnt  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(start) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && i_req[idx[IDW-1:0]]) begin
                found                 = 1'b1;
                rr_gnt[idx[IDW-1:0]]  = 1'b1;
                gnt_idx               = idx[IDW-1:0];
            end
        end
    end

    assign o_gnt = (rst_n && adv) ? rr_gnt : '0;
    assign xfer  = |o_gnt;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            if (lock_hit) begin
                ptr_d = gnt_idx;
            end else if (gnt_idx == IDW'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + IDW'(1);
            end
        end
    end

    always_comb begin
        in_e       = '0;
        in_e.valid = xfer;
        in_e.data  = |(o_gnt & i_data);
        in_e.id    = MAX_IDW'(gnt_idx);
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        logic [STAGE_W-1:0] d_w;
        if (s == 0) begin : g_head
            assign d_w = in_e;
        end else begin : g_body
            assign d_w = stg_raw[s-1];
        end
        chain_stage #(.W(STAGE_W)) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (adv),
            .d_i   (d_w),
            .q_o   (stg_raw[s])
        );
        assign stg_q[s]  = stage_t'(stg_raw[s]);
        assign o_taps[s] = stg_q[s].data;
        assign vld[s]    = stg_q[s].valid;
    end

    // Occupancy after this edge decides whether the chain drains to idle.
    always_comb begin
        vld_nxt = vld;
        if (adv) begin
            vld_nxt[0] = xfer;
            for (int s = 1; s < DEPTH; s++) begin
                vld_nxt[s] = vld[s-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (xfer) state_d = ARB_FLOW;
            end
            ARB_FLOW: begin
                if (o_valid && !i_ready) state_d = ARB_STALL;
                else if (!(|vld_nxt))    state_d = ARB_IDLE;
            end
            ARB_STALL: begin
                if (i_ready) state_d = (|vld_nxt) ? ARB_FLOW : ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_valid   = stg_q[DEPTH-1].valid;
    assign o_data    = stg_q[DEPTH-1].data;
    assign o_id      = stg_q[DEPTH-1].id[IDW-1:0];
    assign o_busy    = (state_q != ARB_IDLE);
    assign unused_id = ^stg_q[DEPTH-1].id;

endmodule

// File: tb/tb_chain_rr_arbiter.sv
// Self-checking bench for chain_rr_arbiter: reference model plus
// (id,data) scoreboard, and directed scenarios; lock test with CHAIN_ARB_LOCK_EN.
module tb_chain_rr_arbiter;
    import chain_arb_pkg::*;

    localparam int N = 4;
    localparam int D = 3;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic [N-1:0] i_req  = '0;
    logic [N-1:0] i_data = '0;
    logic         i_ready = 1'b1;
    logic [N-1:0] o_gnt;
    logic         o_valid;
    logic         o_data;
    logic [1:0]   o_id;
    logic [D-1:0] o_taps;
    logic         o_busy;
`ifdef CHAIN_ARB_LOCK_EN
    logic [N-1:0] i_lock = '0;
`endif

    always #5 clk = ~clk;

    chain_rr_arbiter #(.NUM_REQ(N), .DEPTH(D)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_req),
        .i_data  (i_data),
        .o_gnt   (o_gnt),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_id    (o_id),
        .o_taps  (o_taps),
        .i_ready (i_ready),
`ifdef CHAIN_ARB_LOCK_EN
        .i_lock  (i_lock),
`endif
        .o_busy  (o_busy)
    );

    typedef struct {
        int id;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    int   mv[D];
    int   md[D];
    int   mid[D];
    int   mptr  = 0;
    bit   mlock = 1'b0;

    function automatic logic [N-1:0] rr(int p, logic [N-1:0] req);
        for (int i = 0; i < N; i++) begin
            int k = (p + i) % N;
            if (req[k]) return N'(1) << k;
        end
        return '0;
    endfunction

    function automatic int idx_of(logic [N-1:0] g);
        for (int i = 0; i < N; i++) begin
            if (g[i]) return i;
        end
        return 0;
    endfunction

    function automatic int start_of();
        int st = mptr;
`ifdef CHAIN_ARB_LOCK_EN
        if (mlock && !(i_req[mptr] && i_lock[mptr])) st = (mptr + 1) % N;
`endif
        return st;
    endfunction

    // Reference model: advances on every rising edge with the same inputs.
    always @(posedge clk) begin
        logic [N-1:0] g;
        int           k;
        bit           adv;
        adv = !(mv[D-1] != 0 && !i_ready);
        if (!rst_n) begin
            for (int s = 0; s < D; s++) begin
                mv[s] = 0; md[s] = 0; mid[s] = 0;
            end
            mptr  = 0;
            mlock = 1'b0;
            exp_q.delete();
        end else if (adv) begin
            g = rr(start_of(), i_req);
            k = idx_of(g);
            for (int s = D - 1; s > 0; s--) begin
                mv[s] = mv[s-1]; md[s] = md[s-1]; mid[s] = mid[s-1];
            end
            mv[0]  = (g != 0) ? 1 : 0;
            md[0]  = (g != 0) ? int'(i_data[k]) : 0;
            mid[0] = (g != 0) ? k : 0;
            if (g != 0) begin
                exp_q.push_back('{k, int'(i_data[k])});
                mptr  = (k + 1) % N;
                mlock = 1'b0;
`ifdef CHAIN_ARB_LOCK_EN
                if (i_lock[k]) begin
                    mptr  = k;
                    mlock = 1'b1;
                end
`endif
            end
        end
    end

    // Per-cycle monitor: grant, occupancy and in-order delivery.
    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic [D-1:0] et;
        exp_t         e;
        bit           any;
        if (mon_en) begin
            eg = (rst_n && !(mv[D-1] != 0 && !i_ready)) ?
                 rr(start_of(), i_req) : '0;
            any = 1'b0;
            for (int s = 0; s < D; s++) begin
                et[s] = md[s][0];
                if (mv[s] != 0) any = 1'b1;
            end
            checks++;
            if (o_gnt !== eg) begin
                failures++;
                $display("FAIL mon_gnt t=%0t got=%b exp=%b", $time, o_gnt, eg);
            end
            checks++;
            if (o_valid !== (mv[D-1] != 0)) begin
                failures++;
                $display("FAIL mon_valid t=%0t got=%b exp=%0d", $time, o_valid, mv[D-1]);
            end
            checks++;
            if (o_taps !== et) begin
                failures++;
                $display("FAIL mon_taps t=%0t got=%b exp=%b", $time, o_taps, et);
            end
            checks++;
            if (o_busy !== any) begin
                failures++;
                $display("FAIL mon_busy t=%0t got=%b exp=%b", $time, o_busy, any);
            end
            if (mv[D-1] != 0 && i_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_empty t=%0t got id=%0d data=%b exp=none", $time, o_id, o_data);
                end else begin
                    e = exp_q.pop_front();
                    if (o_id !== e.id[1:0] || o_data !== e.data[0]) begin
                        failures++;
                        $display("FAIL sb_out t=%0t got id=%0d data=%b exp id=%0d data=%0d",
                                 $time, o_id, o_data, e.id, e.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_req   = 4'b1111;
        i_data  = 4'b1010;
        i_ready = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (o_gnt !== 4'b0000) begin
            failures++;
            $display("FAIL reset_gnt got=%b exp=0000", o_gnt);
        end
        checks++;
        if ({o_valid, o_data, o_id, o_taps, o_busy} !== 8'b0) begin
            failures++;
            $display("FAIL reset_outs got v=%b d=%b id=%0d taps=%b busy=%b exp all 0",
                     o_valid, o_data, o_id, o_taps, o_busy);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_gnt !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_gnt got=%b exp=0001", o_gnt);
        end
    endtask

    task automatic test_round_robin();
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (o_gnt !== (N'(1) << (c % 4))) begin
                failures++;
                $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, o_gnt, N'(1) << (c % 4));
            end
            checks++;
            if (o_valid !== (c >= 3)) begin
                failures++;
                $display("FAIL rr_latency c=%0d got=%b exp=%b", c, o_valid, c >= 3);
            end
            if (c >= 3) begin
                checks++;
                if (o_id !== 2'(c - 3) || o_data !== 1'((c - 3) % 2)) begin
                    failures++;
                    $display("FAIL rr_out c=%0d got id=%0d data=%b exp id=%0d data=%0d",
                             c, o_id, o_data, c - 3, (c - 3) % 2);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [D-1:0] et;
        int           ed;
        int           eid;
        tick();
        i_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 0) begin
                ed  = md[D-1];
                eid = mid[D-1];
                for (int s = 0; s < D; s++) et[s] = md[s][0];
            end
            checks++;
            if (o_gnt !== '0 || o_busy !== 1'b1) begin
                failures++;
                $display("FAIL stall_gnt j=%0d got gnt=%b busy=%b exp gnt=0000 busy=1",
                         j, o_gnt, o_busy);
            end
            checks++;
            if (o_data !== ed[0] || o_id !== 2'(eid) || o_taps !== et) begin
                failures++;
                $display("FAIL stall_freeze j=%0d got d=%b id=%0d taps=%b exp d=%0d id=%0d taps=%b",
                         j, o_data, o_id, o_taps, ed, eid, et);
            end
            if (j > 0) begin
                checks++;
                if (dut.state_q !== ARB_STALL) begin
                    failures++;
                    $display("FAIL stall_state j=%0d got=%0d exp=%0d", j, dut.state_q, ARB_STALL);
                end
            end
        end
        tick();
        i_ready = 1'b1;
        repeat (4) tick();
        i_req = '0;
        repeat (6) tick();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_drain got pending=%0d busy=%b exp pending=0 busy=0",
                     exp_q.size(), o_busy);
        end
    endtask

    task automatic test_sparse();
        logic [D-1:0] tap_exp [3];
        tap_exp[0] = 3'b001;
        tap_exp[1] = 3'b010;
        tap_exp[2] = 3'b100;
        tick();
        i_req  = 4'b0100;
        i_data = 4'b0100;
        @(negedge clk);
        checks++;
        if (o_gnt !== 4'b0100) begin
            failures++;
            $display("FAIL sparse_gnt got=%b exp=0100", o_gnt);
        end
        tick();
        i_req = '0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++;
            if (o_taps !== tap_exp[s] || o_busy !== 1'b1 || o_valid !== (s == 2)) begin
                failures++;
                $display("FAIL sparse_taps s=%0d got taps=%b busy=%b v=%b exp taps=%b busy=1 v=%b",
                         s, o_taps, o_busy, o_valid, tap_exp[s], s == 2);
            end
        end
        checks++;
        if (o_id !== 2'd2 || o_data !== 1'b1) begin
            failures++;
            $display("FAIL sparse_out got id=%0d data=%b exp id=2 data=1", o_id, o_data);
        end
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || dut.state_q !== ARB_IDLE) begin
            failures++;
            $display("FAIL sparse_idle got v=%b busy=%b state=%0d exp v=0 busy=0 state=%0d",
                     o_valid, o_busy, dut.state_q, ARB_IDLE);
        end
    endtask

    task automatic test_midreset();
        tick();
        i_req  = 4'b1111;
        i_data = 4'b0110;
        repeat (3) @(negedge clk);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (o_gnt !== '0 || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre got gnt=%b v=%b exp gnt=0000 v=1", o_gnt, o_valid);
        end
        tick();
        rst_n = 1'b1;
        i_req = '0;
        @(negedge clk);
        checks++;
        if ({o_valid, o_data, o_id, o_taps, o_busy} !== 8'b0) begin
            failures++;
            $display("FAIL midrst_clear got v=%b d=%b id=%0d taps=%b busy=%b exp all 0",
                     o_valid, o_data, o_id, o_taps, o_busy);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0) begin
                failures++;
                $display("FAIL midrst_stale c=%0d got v=%b exp v=0", c, o_valid);
            end
        end
    endtask

`ifdef CHAIN_ARB_LOCK_EN
    task automatic test_lock();
        logic [N-1:0] gexp [6];
        gexp[0] = 4'b0001; gexp[1] = 4'b0001; gexp[2] = 4'b0001;
        gexp[3] = 4'b0010; gexp[4] = 4'b0001; gexp[5] = 4'b0010;
        tick();
        i_req  = 4'b0011;
        i_data = 4'b0011;
        i_lock = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin
                tick();
                i_lock = '0;
            end
            @(negedge clk);
            checks++;
            if (o_gnt !== gexp[c]) begin
                failures++;
                $display("FAIL lock_gnt c=%0d got=%b exp=%b", c, o_gnt, gexp[c]);
            end
        end
        tick();
        i_req = '0;
        repeat (5) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_sparse();
        test_midreset();
`ifdef CHAIN_ARB_LOCK_EN
        test_lock();
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chain_rr_arbiter.md
# chain_rr_arbiter

Round-robin arbiter that shares a single-bit, DEPTH-stage pipelined chain between NUM_REQ requesters. It sits in front of the stage chain in the top-level design model. Each accepted bit is tagged with its requester id and delivered at the chain output after DEPTH cycles, with downstream backpressure. A small state machine tracks whether the chain is empty, flowing or stalled.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..16.
- DEPTH, 3: number of chain stages, which is also the latency in cycles; legal range 1..8.
- IDW, $clog2(NUM_REQ): id width; derived, not overridable.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- i_req  input  NUM_REQ  per-requester request.
- i_data  input  NUM_REQ  per-requester data bit.
- o_gnt  output  NUM_REQ  one-hot grant; combinational from i_req, the pointer and the stall condition.
- o_valid  output  1  chain output valid.
- o_data  output  1  chain output bit.
- o_id  output  IDW  requester id of o_data.
- o_taps  output  DEPTH  data bit of every stage; bit 0 is the first stage.
- i_ready  input  1  downstream accept.
- o_busy  output  1  high when any stage holds a valid entry.

## Operation
- Transfer occurs when i_req[k] && o_gnt[k]; the requester's data bit and id enter stage 0.
- Grant selection: the first requesting index at or above ptr, wrapping modulo NUM_REQ. At most one grant bit is set.
- After a transfer from index k, ptr becomes (k+1) mod NUM_REQ. With no transfer, ptr is unchanged.
- Advance condition: adv = !(o_valid && !i_ready). When adv is low, every stage holds and o_gnt is all-zero.
- When adv is high, all stages shift by one. Stage 0 loads the transfer, or a bubble (valid=0) if there is none.
- Bubbles are not collapsed.
- o_valid, o_data and o_id come from the last stage.
- State machine, one state per cycle:
  - IDLE: all stages invalid. Go to FLOW on a transfer.
  - FLOW: some stage valid and adv high. Go to STALL when the last stage is valid and i_ready is low. Go to IDLE when the pipeline drains with no transfer.
  - STALL: go to FLOW when i_ready is high.
- o_busy = (state != IDLE).
- Reset values: ptr=0, all stage valid/data/id=0, state=IDLE. Outputs are therefore o_valid=0, o_data=0, o_id=0, o_taps=0, o_busy=0 and o_gnt=0, even if i_req is high during reset.
- Reset asserted mid-operation discards every in-flight entry on the next edge. No output is emitted afterwards.
- Simultaneous events: a transfer and a last-stage delivery (o_valid && i_ready) in the same cycle are both legal and both occur.

## Timing
- Latency: a transfer at edge n gives o_valid at edge n+DEPTH, provided no stall occurs.
- Throughput: one transfer per cycle while adv is high.
- A stall freezes the pipeline for exactly the cycles where o_valid=1 and i_ready=0. Output data and id are stable throughout.
- o_gnt has a combinational path from i_req and i_ready. There is no combinational path from i_data.

## Configuration
- CHAIN_ARB_LOCK_EN defined:
  - Adds input i_lock (NUM_REQ bits).
  - After a transfer from k with i_lock[k]=1, ptr stays at k, so k keeps priority while it holds i_req and i_lock.
  - Dropping i_req[k] or i_lock[k] resumes normal rotation from k+1.
- CHAIN_ARB_LOCK_EN undefined:
  - There is no i_lock port.
  - The block is pure round-robin.

## Structure
- Package chain_arb_pkg contains:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_FLOW, ARB_STALL} arb_state_t;
  - the stage entry struct {valid, data, id}, using a package parameter for maximum id width;
  - localparams for the NUM_REQ and DEPTH limits.
- One sub-module, chain_stage: a single pipeline register with an enable and synchronous active-low reset. It is instantiated DEPTH times through generate.

## Test plan
- Reset behaviour: hold rst_n=0 with i_req=4'b1111 → o_gnt=0 and all outputs 0. Release reset → o_gnt=4'b0001 on the first cycle.
- Full round robin: i_req=4'b1111, i_data=4'b1010, i_ready=1 → grants in order 0,1,2,3,0; o_valid starts 3 cycles after the first transfer; output sequence (id,data) is (0,0),(1,1),(2,0),(3,1).
- Output stall: from a full pipeline, drop i_ready for 5 cycles → o_gnt=0 throughout; o_data, o_id and o_taps are frozen; state=ARB_STALL; after i_ready returns, the order resumes with no loss or duplication.
- Sparse requests: only requester 2 pulses once → o_taps shows the bit moving from 3'b001 to 3'b010 to 3'b100; o_valid asserts with o_id=2, then state returns to ARB_IDLE and o_busy drops.
- Mid-flight reset: reset asserted with 3 entries in flight → outputs are 0 on the next edge and no stale output appears after release.
- Lock (CHAIN_ARB_LOCK_EN defined): i_req=4'b0011 with i_lock=4'b0001 → grants 0,0,0; then clearing i_lock → grants 1,0,1.
